// File: rtl/elbeth_mem_arbiter_pkg.sv
// Shared constants for the elbeth memory arbiter: address limit, FSM state codes, grant selector.
package elbeth_mem_arbiter_pkg;

  // Addresses at or above this never reach elbeth_memory (its exception bits are sticky).
  localparam logic [31:0] LIMIT_INSTRUC = 32'h0000_0400;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2,
    ARB_ERR    = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_SEL_I = 1'b0,
    ARB_SEL_D = 1'b1
  } arb_sel_e;

endpackage

// File: rtl/elbeth_mem_arbiter_if.sv
// Fetch port, load/store port and memory-side signals of the elbeth memory arbiter.
// slave = arbiter view; master = core plus memory view.
interface elbeth_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          i_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic          mem_read_e;
  logic          mem_write_e;
  logic [AW-1:0] mem_pc_addr;
  logic [AW-1:0] mem_save_addr;
  logic [DW-1:0] mem_data_w;
  logic [DW-1:0] mem_instruction;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_instruction,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_read_e, mem_write_e, mem_pc_addr, mem_save_addr, mem_data_w
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_instruction,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_read_e, mem_write_e, mem_pc_addr, mem_save_addr, mem_data_w
  );
endinterface

// File: rtl/elbeth_mem_arbiter_pick.sv
// Combinational I/D winner select. ELBETH_ARB_RR_EN: ties alternate on last_grant;
// otherwise D wins ties unless the starvation guard (starve_hit) forces I.
module elbeth_arb_pick
  import elbeth_mem_arbiter_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_sel_e last_grant,
  input  logic     starve_hit,
  output arb_sel_e sel
);

`ifdef ELBETH_ARB_RR_EN
  logic unused_starve;
  assign unused_starve = starve_hit;

  always_comb begin
    sel = ARB_SEL_D;
    if (i_req && d_req) begin
      sel = (last_grant == ARB_SEL_D) ? ARB_SEL_I : ARB_SEL_D;
    end else if (i_req) begin
      sel = ARB_SEL_I;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_grant;

  always_comb begin
    sel = ARB_SEL_D;
    if (i_req && d_req) begin
      sel = starve_hit ? ARB_SEL_I : ARB_SEL_D;
    end else if (i_req) begin
      sel = ARB_SEL_I;
    end
  end
`endif

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Single-transaction arbiter for elbeth_memory: req seen at edge N -> gnt in N+1 -> rvalid in N+2.
// Requesters hold req until gnt; option ELBETH_ARB_RR_EN selects round-robin instead of D priority.
module elbeth_mem_arbiter
  import elbeth_mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  elbeth_mem_arbiter_if.slave bus
);

  arb_state_e    state_q;
  arb_sel_e      sel;
  arb_sel_e      sel_q;
  arb_sel_e      last_grant;
  logic          we_q;
  logic          starve_hit;
  logic          any_req;
  logic          arb_pt;
  logic [AW-1:0] win_addr;
  logic          win_we;
  logic          win_oor;

  elbeth_arb_pick u_pick (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant),
    .starve_hit (starve_hit),
    .sel        (sel)
  );

  assign any_req  = bus.i_req | bus.d_req;
  assign arb_pt   = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
  assign win_addr = (sel == ARB_SEL_I) ? bus.i_addr : bus.d_addr;
  assign win_we   = (sel == ARB_SEL_D) && bus.d_we;
  assign win_oor  = (win_addr >= AW'(LIMIT_INSTRUC));

  // Read data is only meaningful in the RESP cycle; zero it elsewhere.
  assign bus.i_rdata = (bus.i_rvalid && !bus.i_err) ? bus.mem_instruction : '0;
  assign bus.d_rdata = (bus.d_rvalid && !bus.d_err) ? bus.mem_instruction : '0;

`ifdef ELBETH_ARB_RR_EN
  assign starve_hit = 1'b0;
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
  logic [CW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == STARVE_LIM);

  // Counts arbitrations I lost; the saturated value forces the next grant to I.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (arb_pt && any_req) begin
      if (sel == ARB_SEL_I) begin
        starve_cnt <= '0;
      end else if (bus.i_req && !starve_hit) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= ARB_IDLE;
      sel_q             <= ARB_SEL_D;
      last_grant        <= ARB_SEL_D;
      we_q              <= 1'b0;
      bus.i_gnt         <= 1'b0;
      bus.i_rvalid      <= 1'b0;
      bus.i_err         <= 1'b0;
      bus.d_gnt         <= 1'b0;
      bus.d_rvalid      <= 1'b0;
      bus.d_err         <= 1'b0;
      bus.mem_read_e    <= 1'b0;
      bus.mem_write_e   <= 1'b0;
      bus.mem_pc_addr   <= '0;
      bus.mem_save_addr <= '0;
      bus.mem_data_w    <= '0;
    end else begin
      bus.i_gnt       <= 1'b0;
      bus.i_rvalid    <= 1'b0;
      bus.i_err       <= 1'b0;
      bus.d_gnt       <= 1'b0;
      bus.d_rvalid    <= 1'b0;
      bus.d_err       <= 1'b0;
      bus.mem_read_e  <= 1'b0;
      bus.mem_write_e <= 1'b0;
      case (state_q)
        ARB_IDLE, ARB_RESP: begin
          state_q <= ARB_IDLE;
          if (any_req) begin
            sel_q      <= sel;
            last_grant <= sel;
            we_q       <= win_we;
            bus.i_gnt  <= (sel == ARB_SEL_I);
            bus.d_gnt  <= (sel == ARB_SEL_D);
            if (win_oor) begin
              state_q      <= ARB_ERR;
              bus.i_rvalid <= (sel == ARB_SEL_I);
              bus.i_err    <= (sel == ARB_SEL_I);
              bus.d_rvalid <= (sel == ARB_SEL_D);
              bus.d_err    <= (sel == ARB_SEL_D);
            end else begin
              state_q <= ARB_ACCESS;
              if (win_we) begin
                bus.mem_write_e   <= 1'b1;
                bus.mem_save_addr <= win_addr;
                bus.mem_data_w    <= bus.d_wdata;
              end else begin
                bus.mem_read_e  <= 1'b1;
                bus.mem_pc_addr <= win_addr;
              end
            end
          end
        end
        ARB_ACCESS: begin
          if (we_q) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q      <= ARB_RESP;
            bus.i_rvalid <= (sel_q == ARB_SEL_I);
            bus.d_rvalid <= (sel_q == ARB_SEL_D);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
